// File: rtl/sw_logic_led_unit.sv
// Switch-to-LED logic unit: debounced operands, button-stepped bitwise op, registered LEDs.
// Optional macro SW_LOGIC_LED_MODEFLASH_EN: led briefly shows the new mode code after each change.
module sw_logic_led_unit #(
  parameter int W            = 4,
  parameter int DEB_CYCLES   = 1000000,
  parameter int FLASH_CYCLES = 50000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*W-1:0] sw,
  input  logic           btn_mode,
  output logic [W-1:0]   led,
  output logic [2:0]     mode_led,
  output logic           mode_chg
);

  localparam int N  = 2 * W + 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    MODE_PASS = 3'd0,
    MODE_NOT  = 3'd1,
    MODE_OR   = 3'd2,
    MODE_AND  = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_NAND = 3'd5
  } mode_t;

  logic [N-1:0]  raw;
  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  db;
  logic [CW-1:0] cnt [N];

  logic [W-1:0]  a_db;
  logic [W-1:0]  b_db;
  logic          btn_db;
  logic          btn_q;
  logic          btn_rise;

  mode_t         mode_q;
  mode_t         mode_d;
  logic [W-1:0]  result;
  logic [W-1:0]  led_d;

  assign raw = {btn_mode, sw};

  // NOTE: the per-bit counters are plain flops, so they sit in the async reset
  // like any other state; a pending debounce must not survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make the two sync stages shift as real flops.
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign a_db     = db[W-1:0];
  assign b_db     = db[2*W-1:W];
  assign btn_db   = db[2*W];
  assign btn_rise = btn_db & ~btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q    <= 1'b0;
      mode_q   <= MODE_PASS;
      mode_chg <= 1'b0;
    end else begin
      btn_q    <= btn_db;
      mode_q   <= mode_d;
      mode_chg <= btn_rise;
    end
  end

  // NOTE: mode_d gets its default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    mode_d = mode_q;
    if (btn_rise) begin
      case (mode_q)
        MODE_PASS: mode_d = MODE_NOT;
        MODE_NOT:  mode_d = MODE_OR;
        MODE_OR:   mode_d = MODE_AND;
        MODE_AND:  mode_d = MODE_XOR;
        MODE_XOR:  mode_d = MODE_NAND;
        default:   mode_d = MODE_PASS;  // NAND wraps; stray codes 6/7 recover to PASS
      endcase
    end
  end

  always_comb begin
    result = a_db;
    case (mode_q)
      MODE_NOT:  result = ~a_db;
      MODE_OR:   result = a_db | b_db;
      MODE_AND:  result = a_db & b_db;
      MODE_XOR:  result = a_db ^ b_db;
      MODE_NAND: result = ~(a_db & b_db);
      default:   result = a_db;
    endcase
  end

`ifdef SW_LOGIC_LED_MODEFLASH_EN
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  logic [FW-1:0] flash_cnt;

  // Loaded on the same edge the mode register updates, so the code shows for FLASH_CYCLES led updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
    end else if (btn_rise) begin
      flash_cnt <= FW'(FLASH_CYCLES);
    end else if (flash_cnt != '0) begin
      flash_cnt <= flash_cnt - FW'(1);
    end
  end

  assign led_d = (flash_cnt != '0) ? W'(mode_q) : result;
`else
  logic unused_flash;
  assign unused_flash = (FLASH_CYCLES != 0);
  assign led_d        = result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_d;
    end
  end

  assign mode_led = mode_q;

endmodule
